// File: rtl/codec_iic_pkg.sv
// Shared types and constants for the codec I2C write master: FSM states,
// quarter index type and the per-state SCL/SDA levels.
package codec_iic_pkg;

    typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_e;

    typedef logic [1:0] quarter_t;

    localparam logic RW_WRITE       = 1'b0;
    localparam int   BITS_PER_FRAME = 9;

    // Returns {scl, sda_oe} for a state and quarter; sda_oe=1 pulls SDA low.
    function automatic logic [1:0] bus_levels(state_e s, quarter_t q, logic data_bit);
        logic [1:0] lv;
        lv = 2'b10;
        case (s)
            START: begin
                case (q)
                    2'd0, 2'd1: lv = 2'b10;
                    2'd2:       lv = 2'b11;
                    default:    lv = 2'b01;
                endcase
            end
            BIT:  lv = {q[1], ~data_bit};
            ACK:  lv = {q[1], 1'b0};
            STOP: begin
                case (q)
                    2'd0, 2'd1: lv = 2'b01;
                    2'd2:       lv = 2'b11;
                    default:    lv = 2'b10;
                endcase
            end
            default: lv = 2'b10;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/iic_quarter_tick.sv
// Quarter-period timebase: counts 0..DIV-1, ticks on DIV-1 and advances a
// 2-bit quarter index. Synchronous clear and a hold input for SCL stretching.
module iic_quarter_tick
    import codec_iic_pkg::*;
#(
    parameter int DIV = 125
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     clr_i,
    input  logic     hold_i,
    output logic     tick_o,
    output quarter_t quarter_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    quarter_t      quarter_q;

    assign tick_o    = (cnt_q == LAST) && !hold_i && !clr_i;
    assign quarter_o = quarter_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q     <= '0;
            quarter_q <= '0;
        end else if (!hold_i) begin
            if (cnt_q == LAST) begin
                cnt_q     <= '0;
                quarter_q <= quarter_q + 2'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/codec_iic_master.sv
// I2C write master for the codec config bus: START, address+W, payload bytes
// with ACK checks, STOP. Optional slave clock stretching: IIC_CLOCK_STRETCH_EN.
module codec_iic_master
    import codec_iic_pkg::*;
#(
    parameter int DIV       = 125,
    parameter int MAX_BYTES = 4,
    parameter int CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset,
    input  logic                   start,
    input  logic [6:0]             dev_addr,
    input  logic [8*MAX_BYTES-1:0] payload,
    input  logic [CNT_W-1:0]       byte_count,
    output logic                   busy,
    output logic                   done,
    output logic                   ack_error,
    output logic                   iic_scl_out,
    output logic                   iic_sda_oe,
    input  logic                   iic_sda_in
`ifdef IIC_CLOCK_STRETCH_EN
    ,
    input  logic                   iic_scl_in
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_BYTES);
    localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_FRAME - 2);

    state_e                 state_q;
    logic                   busy_q, done_q, ack_error_q, scl_q, sda_oe_q;
    logic [7:0]             sh_q;
    logic [8*MAX_BYTES-1:0] payload_q;
    logic [CNT_W-1:0]       bytes_left_q;
    logic [2:0]             bit_q;

    logic     tick, hold, clr;
    quarter_t quarter;

    assign clr = (state_q == IDLE);

`ifdef IIC_CLOCK_STRETCH_EN
    // Only stretch once we are already releasing SCL high; otherwise the
    // one-cycle output register lag would read our own low level as a stretch.
    assign hold = scl_q && !iic_scl_in && quarter[1] &&
                  (state_q inside {START, BIT, ACK, STOP});
`else
    assign hold = 1'b0;
`endif

    iic_quarter_tick #(.DIV(DIV)) u_tick (
        .clk_i     (clk_clk),
        .rst_i     (reset_reset),
        .clr_i     (clr),
        .hold_i    (hold),
        .tick_o    (tick),
        .quarter_o (quarter)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ack_error_q  <= 1'b0;
            scl_q        <= 1'b1;
            sda_oe_q     <= 1'b0;
            sh_q         <= '0;
            payload_q    <= '0;
            bytes_left_q <= '0;
            bit_q        <= '0;
        end else begin
            done_q <= 1'b0;
            {scl_q, sda_oe_q} <= bus_levels(state_q, quarter, sh_q[7]);
            case (state_q)
                IDLE: begin
                    // The cycle carrying done is still closing the previous transfer.
                    if (start && !done_q) begin
                        state_q      <= START;
                        busy_q       <= 1'b1;
                        ack_error_q  <= 1'b0;
                        sh_q         <= {dev_addr, RW_WRITE};
                        payload_q    <= payload;
                        bytes_left_q <= (byte_count > MAX_CNT) ? MAX_CNT : byte_count;
                        bit_q        <= '0;
                    end
                end
                START: begin
                    if (tick && quarter == 2'd3) state_q <= BIT;
                end
                BIT: begin
                    if (tick && quarter == 2'd3) begin
                        sh_q <= {sh_q[6:0], 1'b0};
                        if (bit_q == LAST_BIT) begin
                            bit_q   <= '0;
                            state_q <= ACK;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end
                end
                ACK: begin
                    if (tick && quarter == 2'd2 && iic_sda_in) ack_error_q <= 1'b1;
                    if (tick && quarter == 2'd3) begin
                        if (!ack_error_q && bytes_left_q != '0) begin
                            state_q      <= BIT;
                            sh_q         <= payload_q[7:0];
                            payload_q    <= payload_q >> 8;
                            bytes_left_q <= bytes_left_q - 1'b1;
                        end else begin
                            state_q <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (tick && quarter == 2'd3) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_error   = ack_error_q;
    assign iic_scl_out = scl_q;
    assign iic_sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_codec_iic_master.sv
// Bench for codec_iic_master: a bus-level slave/monitor decodes START, bytes
// and STOP from the pins; expectations come from the transaction rules.
module tb_codec_iic_master;

  localparam int DIV = 4;
  localparam int MAX_BYTES = 4;
  localparam int CNT_W = 3;

  // clock / reset
  logic clk_clk = 1'b0;
  logic reset_reset;
  always #5 clk_clk = ~clk_clk;

  logic                   start;
  logic [6:0]             dev_addr;
  logic [8*MAX_BYTES-1:0] payload;
  logic [CNT_W-1:0]       byte_count;
  logic                   busy, done, ack_error, iic_scl_out, iic_sda_oe, iic_sda_in;
  logic                   slave_low = 1'b0;
  logic                   slave_scl_low = 1'b0;

  assign iic_sda_in = !(iic_sda_oe || slave_low);

`ifdef IIC_CLOCK_STRETCH_EN
  logic iic_scl_in;
  assign iic_scl_in = iic_scl_out && !slave_scl_low;
`endif

  codec_iic_master #(.DIV(DIV), .MAX_BYTES(MAX_BYTES), .CNT_W(CNT_W)) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .start       (start),
    .dev_addr    (dev_addr),
    .payload     (payload),
    .byte_count  (byte_count),
    .busy        (busy),
    .done        (done),
    .ack_error   (ack_error),
    .iic_scl_out (iic_scl_out),
    .iic_sda_oe  (iic_sda_oe),
    .iic_sda_in  (iic_sda_in)
`ifdef IIC_CLOCK_STRETCH_EN
    ,
    .iic_scl_in  (iic_scl_in)
`endif
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bus monitor and slave model (wired-AND bus, sampled on negedge)
  int   bit_cnt = 0, frame_idx = 0, starts = 0, stops = 0, stretch_cnt = 0;
  int   nack_frame = -1;
  bit   mon_clr = 1'b1, stretch_req = 1'b0, stretched = 1'b0;
  bit   prev_scl = 1'b1, prev_sda = 1'b1, prev_out = 1'b1;
  logic scl_b, sda_b;
  logic [7:0] shift_r = 8'h00;

  always @(negedge clk_clk) begin
    if (stretch_cnt > 0) stretch_cnt--;
    if (!mon_clr && stretch_req && !stretched && frame_idx == 0 && bit_cnt == 3 &&
        iic_scl_out && !prev_out) begin
      stretch_cnt = 10;
      stretched = 1'b1;
    end
    slave_scl_low = (stretch_cnt > 0);
    scl_b = iic_scl_out && !slave_scl_low;
    sda_b = !(iic_sda_oe || slave_low);
    if (mon_clr) begin
      bit_cnt = 0; frame_idx = 0; starts = 0; stops = 0;
      slave_low = 1'b0; stretched = 1'b0; stretch_cnt = 0; slave_scl_low = 1'b0;
      got_q.delete();
    end else if (prev_scl && scl_b && prev_sda && !sda_b) begin
      starts++; bit_cnt = 0; frame_idx = 0;
    end else if (prev_scl && scl_b && !prev_sda && sda_b) begin
      stops++;
    end else if (!prev_scl && scl_b) begin
      if (bit_cnt < 8) shift_r = {shift_r[6:0], sda_b};
      bit_cnt++;
      if (bit_cnt == 8) got_q.push_back(shift_r);
    end else if (prev_scl && !scl_b) begin
      if (bit_cnt == 8) slave_low = (frame_idx != nack_frame);
      else if (bit_cnt == 9) begin
        slave_low = 1'b0; bit_cnt = 0; frame_idx++;
      end
    end
    prev_out = iic_scl_out; prev_scl = scl_b; prev_sda = sda_b;
  end

  // driver: one transaction plus its end-of-transfer checks
  task automatic run_txn(input logic [6:0] addr, input logic [31:0] pay, input logic [2:0] cnt,
                         input int nack_at, input int poke_at, input int abort_at,
                         input bit stretch, input bit retrig);
    int n_eff, frames, sent, exp_lat, cyc, busy_drop;
    bit exp_err, seen;
    logic [31:0] tmp;
    n_eff   = (cnt > 3'd4) ? 4 : int'(cnt);
    frames  = 1 + n_eff;
    exp_err = (nack_at >= 0 && nack_at < frames);
    sent    = exp_err ? nack_at + 1 : frames;
    exp_lat = 4 * DIV * (2 + 9 * sent) + 1 + (stretch ? 10 : 0);
    exp_q.delete();
    exp_q.push_back({addr, 1'b0});
    for (int k = 1; k < sent; k++) begin
      tmp = pay >> (8 * (k - 1));
      exp_q.push_back(tmp[7:0]);
    end

    @(negedge clk_clk);
    mon_clr = 1'b1; nack_frame = nack_at; stretch_req = stretch;
    dev_addr = addr; payload = pay; byte_count = cnt; start = 1'b1;
    @(posedge clk_clk); #1;
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("err_clear", 32'(ack_error), 32'd0);
    @(negedge clk_clk); #1;
    mon_clr = 1'b0;

    cyc = 0; busy_drop = 0; seen = 1'b0;
    while (cyc < 2000) begin
      @(posedge clk_clk); #1;
      cyc++;
      start = (cyc == poke_at);
      if (cyc == poke_at) begin
        dev_addr = ~addr; payload = ~pay; byte_count = cnt ^ 3'd1;
      end
      if (cyc == abort_at) begin
        reset_reset = 1'b1;
        @(posedge clk_clk); #1;
        reset_reset = 1'b0;
        chk("abort_scl", 32'(iic_scl_out), 32'd1);
        chk("abort_oe", 32'(iic_sda_oe), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(ack_error), 32'd0);
        return;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (!busy) busy_drop++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("ack_error", 32'(ack_error), 32'(exp_err));
    chk("busy_hold", 32'(busy_drop), 32'd0);

    if (retrig) start = 1'b1;
    @(posedge clk_clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);

    chk("n_bytes", 32'(got_q.size()), 32'(exp_q.size()));
    chk("n_start", 32'(starts), 32'd1);
    chk("n_stop", 32'(stops), 32'd1);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int nack;
    reset_reset = 1'b1; start = 1'b0; dev_addr = '0; payload = '0; byte_count = '0;
    repeat (3) @(posedge clk_clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(ack_error), 32'd0);
    chk("rst_scl", 32'(iic_scl_out), 32'd1);
    chk("rst_oe", 32'(iic_sda_oe), 32'd0);
    reset_reset = 1'b0;
    repeat (2) @(posedge clk_clk);

    run_txn(7'h1A, 32'h0000_1E00, 3'd2, -1, 0, 0, 1'b0, 1'b0);
    run_txn(7'h1A, 32'h0000_1E00, 3'd2, 0, 0, 0, 1'b0, 1'b0);
    run_txn(7'h1A, 32'h0000_1E00, 3'd2, -1, 100, 0, 1'b0, 1'b0);
    run_txn(7'h1A, 32'h0000_1E00, 3'd2, -1, 0, 330, 1'b0, 1'b0);
    run_txn(7'h2B, 32'hA5C3_0F81, 3'd2, -1, 0, 0, 1'b0, 1'b0);
    run_txn(7'h55, 32'h0, 3'd0, -1, 0, 0, 1'b0, 1'b0);
    run_txn(7'h7F, 32'h1234_5678, 3'd7, -1, 0, 0, 1'b0, 1'b1);
    run_txn(7'h7F, 32'h1234_5678, 3'd7, 4, 0, 0, 1'b0, 1'b0);
`ifdef IIC_CLOCK_STRETCH_EN
    run_txn(7'h1A, 32'h0000_1E00, 3'd2, -1, 0, 0, 1'b1, 1'b0);
`endif
    for (int r = 0; r < 12; r++) begin
      nack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_txn(7'($urandom), $urandom, 3'($urandom_range(0, 7)), nack, 0, 0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/codec_iic_master.md
Name: codec_iic_master

Overview:
- Hardware I2C write master for the audio codec configuration bus.
- Replaces the bit-banged iicclockbit/iicdatabit GPIO pair: the processor, or a config sequencer, loads a device address plus up to MAX_BYTES payload bytes and pulses start.
- The block generates START, address+W, data bytes, ACK checks and STOP autonomously.
- Sits between the bus-bridge register slave and the top-level SDA inout/SCL pins.

Parameters:
- DIV, 125: clk_clk cycles per quarter SCL period (50 MHz / (4*125) = 100 kHz); legal range >= 2.
- MAX_BYTES, 4: maximum payload bytes per transaction.
- CNT_W, $clog2(MAX_BYTES+1): width of byte_count.

Ports:
- clk_clk  input  1  system clock.
- reset_reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; accepted only when busy=0.
- dev_addr  input  7  7-bit slave address, captured on accept.
- payload  input  8*MAX_BYTES  byte k = payload[8k+7:8k], sent k=0 first; captured on accept.
- byte_count  input  CNT_W  number of payload bytes, 0..MAX_BYTES.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse at end of STOP.
- ack_error  output  1  NACK seen in the last transaction.
- iic_scl_out  output  1  SCL level (push-pull).
- iic_sda_oe  output  1  1 = drive SDA low; 0 = release (external pull-up).
- iic_sda_in  input  1  sampled SDA pin.

Behaviour:
- Reset: busy=0, done=0, ack_error=0, iic_scl_out=1, iic_sda_oe=0, state=IDLE, quarter counter=0.
- Reset mid-transaction aborts on the next edge with the same values. No STOP is generated.
- Quarter tick: counter counts 0..DIV-1 and ticks on DIV-1. Each symbol is 4 quarters q0..q3. The counter runs only when state != IDLE.
- FSM states and outputs:
  - IDLE: SCL=1, SDA released.
  - START: q0-q1 SDA released, SCL=1; q2 SDA low, SCL=1; q3 SDA low, SCL=0.
  - BIT: q0-q1 SCL=0 with SDA set to the data bit (oe = ~bit); q2-q3 SCL=1.
  - ACK: SDA released; SCL as in BIT. iic_sda_in is sampled on the last clk of q2.
  - STOP: q0-q1 SCL=0, SDA low; q2 SCL=1, SDA low; q3 SCL=1, SDA released.
  - DONE: single cycle; done=1, then IDLE.
- Transitions:
  - IDLE -> START on start.
  - START -> BIT (frame 0).
  - BIT -> ACK after 8 bits, MSB first.
  - ACK -> BIT (next frame) if ACK=0 and frames remain; otherwise -> STOP.
  - STOP -> DONE.
- Frame 0 = {dev_addr, 1'b0}, write only. Frames 1..n = payload bytes.
- byte_count > MAX_BYTES is clamped to MAX_BYTES. byte_count = 0 gives an address-only probe.
- NACK (sampled SDA=1) sets ack_error. Remaining frames are skipped and the block goes straight to STOP.
- ack_error is cleared on the next accepted start and holds otherwise.
- Latency: busy rises 1 cycle after accept. done pulses 4*DIV*(2 + 9*(1+n)) + 1 cycles after accept for a fully ACKed transfer of n bytes.
- start while busy is ignored; inputs are not re-captured.
- start on the same cycle as done is not accepted; it may be accepted from the following cycle.

Optional Feature:
- Macro: IIC_CLOCK_STRETCH_EN.
- When defined:
  - Adds input iic_scl_in (1 bit) and makes iic_scl_out open-drain-compatible: the top level drives low only when 0.
  - During q2/q3 of START, BIT, ACK and STOP, the quarter counter holds while iic_scl_in=0 (slave stretching).
  - The ACK sample point moves to the first q2 end after SCL is seen high.
- When not defined: the port is absent and timing is fixed as above.

Decomposition:
- Package codec_iic_pkg holds:
  - state enum (IDLE, START, BIT, ACK, STOP, DONE);
  - quarter index type (2 bits);
  - constants RW_WRITE=1'b0 and BITS_PER_FRAME=9.
- One sub-module: iic_quarter_tick. It is a parametrised DIV counter with sync clear and hold input, and outputs a tick plus a 2-bit quarter index.

Test Plan:
- DIV=4, dev_addr=7'h1A, n=2, payload=16'h1E00, slave ACKs all frames:
  - SDA shows bytes 0x34, 0x00, 0x1E in that order;
  - done pulses 465 cycles after accept;
  - ack_error=0.
- Same transfer with the slave NACKing the address: ack_error=1, STOP follows immediately after the address frame, done pulses 4*4*(2+9)+1 = 177 cycles after accept.
- start pulsed mid-transfer with a different dev_addr: ignored, and the SDA waveform is unchanged.
- Reset asserted during the second payload byte: the next cycle shows SCL=1, oe=0, busy=0, done=0; a new start then works normally.
- byte_count=0 probe, and byte_count=7 with MAX_BYTES=4:
  - probe: 2 symbols + 9 bits;
  - byte_count=7: clamped to 4 bytes (frame count 5).
- With IIC_CLOCK_STRETCH_EN, the slave holds SCL low for 10 cycles during bit 3: the SCL high phase extends by 10 cycles, the data is intact, and done is delayed by exactly 10 cycles.
